// File: rtl/uart_led_link.sv
// -----------------------------------------------------------------------------
// uart_led_link
//   Serial front-end for the PMOD LED-array board. It contains two independent
//   paths that may be active at the same time:
//     * an 8N1 UART receiver that delivers bytes with a one-cycle valid strobe;
//     * a TM1640-style two-wire writer (LCLK/LDIN) that sends either a single
//       command byte or an address+data pair inside one START/STOP frame.
//
// Parameters
//   CLK_HZ    system clock frequency in Hz
//   BAUD      UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (floor)
//   HALF_BIT  system clocks per half period of LCLK (minimum 2)
//
// Ports
//   CLK         system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   RX          UART line, idle high, asynchronous to CLK
//   o_rx_data   last received byte (held until the next byte)
//   o_rx_valid  one-cycle strobe, o_rx_data valid
//   i_valid     write request, sampled only while o_busy = 0
//   i_pos       address command byte, or 8'hFF for a command-only transfer
//   i_value     data / command byte
//   o_lclk      LED driver clock (idle high)
//   o_ldin      LED driver data  (idle high)
//   o_busy      writer busy
//
// Build option
//   UART_FRAME_CHECK_EN  when defined, a stop bit sampled low is a framing
//                        error: no strobe, data unchanged, and the receiver
//                        waits for RX high before re-arming.
// -----------------------------------------------------------------------------
module uart_led_link #(
  parameter int CLK_HZ   = 12_000_000,
  parameter int BAUD     = 115200,
  parameter int HALF_BIT = 6
) (
  input  logic       CLK,
  input  logic       i_rst_n,
  input  logic       RX,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_valid,
  input  logic [7:0] i_pos,
  input  logic [7:0] i_value,
  output logic       o_lclk,
  output logic       o_ldin,
  output logic       o_busy
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID_LAST     = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_fall;
  rx_state_t   rx_state, rx_state_d;
  logic [15:0] rx_cnt, rx_cnt_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic [7:0]  rx_shift, rx_shift_d;
  logic [7:0]  rx_data_d;
  logic        rx_valid_d;

  // Synchronizer and edge-detect history reset to the idle (high) line level
  // so that reset release never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  always_ff @(posedge CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      o_rx_data  <= rx_data_d;
      o_rx_valid <= rx_valid_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + 16'd1;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_data_d  = o_rx_data;
    rx_valid_d = 1'b0;

    case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end

      // Re-sample at mid start bit; a high line means the edge was a glitch.
      RX_START: begin
        if (rx_cnt == MID_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      end

      // Leave at stop-bit mid-point so a start bit that follows immediately
      // is still caught by the edge detector.
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d = '0;
`ifdef UART_FRAME_CHECK_EN
          if (rx_sync) begin
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT_HIGH;
          end
`else
          rx_data_d  = rx_shift;
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
`endif
        end
      end

      RX_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = RX_IDLE;
      end

      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit path (two-wire writer)
  //   Each state lasts HALF_BIT clocks. SETUP + START form the START condition,
  //   BIT_LO/BIT_HI carry one bit, STOP_LO/STOP_HI/STOP_END form STOP.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_START,
    W_BIT_LO,
    W_BIT_HI,
    W_STOP_LO,
    W_STOP_HI,
    W_STOP_END
  } wr_state_t;

  wr_state_t   wr_state, wr_state_d;
  logic [15:0] wr_cnt, wr_cnt_d;
  logic [2:0]  wr_bit, wr_bit_d;
  logic [7:0]  wr_shift, wr_shift_d;
  logic [7:0]  wr_value, wr_value_d;
  logic        wr_second, wr_second_d;
  logic        lclk_d, ldin_d, busy_d;
  logic        phase_end;

  assign phase_end = (wr_cnt == HALF_LAST);

  always_ff @(posedge CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state  <= W_IDLE;
      wr_cnt    <= '0;
      wr_bit    <= '0;
      wr_shift  <= '0;
      wr_value  <= '0;
      wr_second <= 1'b0;
      o_lclk    <= 1'b1;
      o_ldin    <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      wr_state  <= wr_state_d;
      wr_cnt    <= wr_cnt_d;
      wr_bit    <= wr_bit_d;
      wr_shift  <= wr_shift_d;
      wr_value  <= wr_value_d;
      wr_second <= wr_second_d;
      o_lclk    <= lclk_d;
      o_ldin    <= ldin_d;
      o_busy    <= busy_d;
    end
  end

  always_comb begin
    wr_state_d  = wr_state;
    wr_cnt_d    = phase_end ? 16'd0 : wr_cnt + 16'd1;
    wr_bit_d    = wr_bit;
    wr_shift_d  = wr_shift;
    wr_value_d  = wr_value;
    wr_second_d = wr_second;
    lclk_d      = o_lclk;
    ldin_d      = o_ldin;
    busy_d      = o_busy;

    case (wr_state)
      W_IDLE: begin
        wr_cnt_d = '0;
        if (i_valid) begin
          wr_shift_d  = (i_pos == 8'hFF) ? i_value : i_pos;
          wr_value_d  = i_value;
          wr_second_d = (i_pos != 8'hFF);
          wr_bit_d    = '0;
          busy_d      = 1'b1;
          wr_state_d  = W_SETUP;
        end
      end

      // Both lines high for one half period, then LDIN falls with LCLK high.
      W_SETUP: begin
        if (phase_end) begin
          ldin_d     = 1'b0;
          wr_state_d = W_START;
        end
      end

      W_START: begin
        if (phase_end) begin
          lclk_d     = 1'b0;
          wr_state_d = W_BIT_LO;
        end
      end

      // LDIN is updated one clock after LCLK fell, so it never moves on an
      // LCLK edge (this relies on HALF_BIT >= 2).
      W_BIT_LO: begin
        if (wr_cnt == 16'd0) ldin_d = wr_shift[0];
        if (phase_end) begin
          lclk_d     = 1'b1;
          wr_state_d = W_BIT_HI;
        end
      end

      W_BIT_HI: begin
        if (phase_end) begin
          lclk_d = 1'b0;
          if (wr_bit == 3'd7) begin
            wr_bit_d = '0;
            if (wr_second) begin
              wr_shift_d  = wr_value;
              wr_second_d = 1'b0;
              wr_state_d  = W_BIT_LO;
            end else begin
              wr_state_d = W_STOP_LO;
            end
          end else begin
            wr_shift_d = {1'b0, wr_shift[7:1]};
            wr_bit_d   = wr_bit + 3'd1;
            wr_state_d = W_BIT_LO;
          end
        end
      end

      W_STOP_LO: begin
        if (wr_cnt == 16'd0) ldin_d = 1'b0;
        if (phase_end) begin
          lclk_d     = 1'b1;
          wr_state_d = W_STOP_HI;
        end
      end

      // LDIN rises while LCLK is high: the STOP condition.
      W_STOP_HI: begin
        if (phase_end) begin
          ldin_d     = 1'b1;
          wr_state_d = W_STOP_END;
        end
      end

      W_STOP_END: begin
        if (phase_end) begin
          busy_d     = 1'b0;
          wr_state_d = W_IDLE;
        end
      end

      default: wr_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_led_link.sv
// -----------------------------------------------------------------------------
// tb_uart_led_link
//   Directed bench for uart_led_link at default parameters (104 clocks per
//   UART bit, HALF_BIT = 6). Drives UART frames on RX and write requests on
//   the writer port; passive monitors decode o_rx_valid strobes and the
//   LCLK/LDIN START / bit / STOP sequence so the stimulus block can compare
//   them against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_led_link;

  localparam int CPB = 104;
  localparam int HB  = 6;

  logic       CLK;
  logic       i_rst_n;
  logic       RX;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       i_valid;
  logic [7:0] i_pos;
  logic [7:0] i_value;
  logic       o_lclk;
  logic       o_ldin;
  logic       o_busy;

  uart_led_link #(
    .CLK_HZ  (12_000_000),
    .BAUD    (115200),
    .HALF_BIT(HB)
  ) dut (
    .CLK       (CLK),
    .i_rst_n   (i_rst_n),
    .RX        (RX),
    .o_rx_data (o_rx_data),
    .o_rx_valid(o_rx_valid),
    .i_valid   (i_valid),
    .i_pos     (i_pos),
    .i_value   (i_value),
    .o_lclk    (o_lclk),
    .o_ldin    (o_ldin),
    .o_busy    (o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_asserts = 0;
  int n_fail    = 0;

  // ---------------------------------------------------------------------------
  // Receive monitor: every high cycle of o_rx_valid is logged.
  // ---------------------------------------------------------------------------
  int         rxv_cycles = 0;
  logic [7:0] rxv_data[$];
  time        rxv_time   = 0;
  time        t_start    = 0;

  always @(negedge CLK) begin
    if (o_rx_valid === 1'b1) begin
      rxv_cycles++;
      rxv_data.push_back(o_rx_data);
      rxv_time = $time;
    end
  end

  // ---------------------------------------------------------------------------
  // Writer monitor: START = LDIN falls with LCLK high, STOP = LDIN rises with
  // LCLK high; LDIN is captured on every LCLK rising edge in between.
  // ---------------------------------------------------------------------------
  logic        p_lclk   = 1'b1;
  logic        p_ldin   = 1'b1;
  int          starts   = 0;
  int          stops    = 0;
  int          cur_n    = 0;
  int          frm_n    = 0;
  logic [31:0] cur_bits = '0;
  logic [31:0] frm_bits = '0;
  int          busy_run = 0;
  int          busy_len = 0;

  always @(negedge CLK) begin
    if (o_lclk && p_lclk && p_ldin && !o_ldin) begin
      starts++;
      cur_n    = 0;
      cur_bits = '0;
    end else if (o_lclk && p_lclk && !p_ldin && o_ldin) begin
      stops++;
      frm_n    = cur_n;
      frm_bits = cur_bits;
    end
    if (!p_lclk && o_lclk) begin
      if (cur_n < 32) cur_bits[cur_n] = o_ldin;
      cur_n++;
    end
    if (o_busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
    p_lclk = o_lclk;
    p_ldin = o_ldin;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input longint val, input longint lo, input longint hi);
    n_asserts++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Advance n clocks and land 1 ns after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One 8N1 frame with a chosen stop-bit level; leaves RX high afterwards.
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    t_start = $time;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(CPB);
    end
    RX = stop_bit;
    tick(CPB);
    RX = 1'b1;
  endtask

  task automatic wr_req(input logic [7:0] pos, input logic [7:0] val);
    i_pos   = pos;
    i_value = val;
    i_valid = 1'b1;
    tick(1);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (o_busy && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int n0, c0, s0, e0;

  initial begin
    RX      = 1'b1;
    i_valid = 1'b0;
    i_pos   = 8'h00;
    i_value = 8'h00;
    i_rst_n = 1'b0;
    #23;
    check("rst_rx_data",  {24'd0, o_rx_data}, 32'h00);
    check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    check("rst_busy",     {31'd0, o_busy}, 32'd0);
    check("rst_lclk",     {31'd0, o_lclk}, 32'd1);
    check("rst_ldin",     {31'd0, o_ldin}, 32'd1);
    tick(2);
    i_rst_n = 1'b1;
    tick(5);

    // 'A': one strobe at the stop-bit mid-point (~9.5 bits + sync latency).
    n0 = rxv_data.size();
    c0 = rxv_cycles;
    uart_send(8'h41, 1'b1);
    tick(20);
    check("rx_a_count", 32'(rxv_cycles - c0), 32'd1);
    if (rxv_data.size() > n0) check("rx_a_data", {24'd0, rxv_data[n0]}, 32'h41);
    else                      check("rx_a_data", 32'hFFFF_FFFF, 32'h41);
    check("rx_a_hold", {24'd0, o_rx_data}, 32'h41);
    check_range("rx_a_latency_ns", longint'(rxv_time - t_start), 9850, 10000);

    // Back-to-back frames, no idle time between stop and next start.
    n0 = rxv_data.size();
    c0 = rxv_cycles;
    uart_send(8'h55, 1'b1);
    uart_send(8'hAA, 1'b1);
    tick(20);
    check("rx_b2b_count", 32'(rxv_cycles - c0), 32'd2);
    if (rxv_data.size() >= n0 + 2) begin
      check("rx_b2b_first",  {24'd0, rxv_data[n0]},     32'h55);
      check("rx_b2b_second", {24'd0, rxv_data[n0 + 1]}, 32'hAA);
    end else begin
      check("rx_b2b_first", 32'hFFFF_FFFF, 32'h55);
    end

    // 20-cycle glitch is rejected at the mid-start re-sample.
    c0 = rxv_cycles;
    RX = 1'b0;
    tick(20);
    RX = 1'b1;
    tick(300);
    check("rx_glitch_count", 32'(rxv_cycles - c0), 32'd0);
    check("rx_glitch_hold",  {24'd0, o_rx_data}, 32'hAA);

    // Stop bit low.
    n0 = rxv_data.size();
    c0 = rxv_cycles;
    uart_send(8'h12, 1'b0);
    tick(20);
`ifdef UART_FRAME_CHECK_EN
    check("rx_frame_err_count", 32'(rxv_cycles - c0), 32'd0);
    check("rx_frame_err_hold",  {24'd0, o_rx_data}, 32'hAA);
`else
    check("rx_bad_stop_count", 32'(rxv_cycles - c0), 32'd1);
    check("rx_bad_stop_data",  {24'd0, o_rx_data}, 32'h12);
`endif
    tick(CPB);
    c0 = rxv_cycles;
    uart_send(8'h3C, 1'b1);
    tick(20);
    check("rx_recover_count", 32'(rxv_cycles - c0), 32'd1);
    check("rx_recover_data",  {24'd0, o_rx_data}, 32'h3C);

    // Command-only write of 0x89: bits 1,0,0,1,0,0,0,1 then the STOP's
    // rising LCLK with LDIN low -> 9 rising edges, 21 half periods busy.
    s0 = stops;
    e0 = starts;
    wr_req(8'hFF, 8'h89);
    check("wr1_busy_set", {31'd0, o_busy}, 32'd1);
    wait_idle("wr1_done", 400);
    tick(3);
    check("wr1_starts", 32'(starts - e0), 32'd1);
    check("wr1_stops",  32'(stops - s0), 32'd1);
    check("wr1_nbits",  32'(frm_n), 32'd9);
    check("wr1_bits",   {23'd0, frm_bits[8:0]}, 32'h089);
    check_range("wr1_busy_len", busy_len, 21 * HB - 1, 21 * HB + 1);

    // Address + data in one frame; a second request while busy is dropped.
    s0 = stops;
    e0 = starts;
    wr_req(8'hC3, 8'h81);
    tick(60);
    check("wr2_busy_mid", {31'd0, o_busy}, 32'd1);
    wr_req(8'h11, 8'h22);
    wait_idle("wr2_done", 600);
    tick(3);
    check("wr2_nbits", 32'(frm_n), 32'd17);
    check("wr2_bits",  {15'd0, frm_bits[16:0]}, 32'h0_81C3);
    check_range("wr2_busy_len", busy_len, 37 * HB - 1, 37 * HB + 1);
    tick(40);
    check("wr2_no_queue_busy", {31'd0, o_busy}, 32'd0);
    check("wr2_starts", 32'(starts - e0), 32'd1);
    check("wr2_stops",  32'(stops - s0), 32'd1);

    // Writer and receiver running at the same time.
    s0 = stops;
    c0 = rxv_cycles;
    wr_req(8'hFF, 8'hA5);
    uart_send(8'h96, 1'b1);
    tick(20);
    check("sim_rx_count", 32'(rxv_cycles - c0), 32'd1);
    check("sim_rx_data",  {24'd0, o_rx_data}, 32'h96);
    check("sim_wr_stops", 32'(stops - s0), 32'd1);
    check("sim_wr_bits",  {23'd0, frm_bits[8:0]}, 32'h0A5);

    // Reset in the middle of a two-byte transfer.
    wr_req(8'h00, 8'hF0);
    tick(50);
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_lclk",    {31'd0, o_lclk}, 32'd1);
    check("rst_mid_ldin",    {31'd0, o_ldin}, 32'd1);
    check("rst_mid_busy",    {31'd0, o_busy}, 32'd0);
    check("rst_mid_rx_data", {24'd0, o_rx_data}, 32'h00);
    tick(2);
    i_rst_n = 1'b1;
    tick(3);
    s0 = stops;
    e0 = starts;
    wr_req(8'hFF, 8'h5A);
    wait_idle("wr3_done", 400);
    tick(3);
    check("wr3_starts", 32'(starts - e0), 32'd1);
    check("wr3_stops",  32'(stops - s0), 32'd1);
    check("wr3_nbits",  32'(frm_n), 32'd9);
    check("wr3_bits",   {23'd0, frm_bits[8:0]}, 32'h05A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_led_link.md
Name: uart_led_link

Overview:
- Combined serial front-end for the PMOD LED-array board.
- Receive path: 8N1 UART receiver delivering bytes with a one-cycle valid strobe.
- Transmit path: TM1640-style two-wire writer (LCLK/LDIN) that sends either a single command byte or an address+data pair.
- Sits between the top-level display/packet state machines and the PMOD pins.

Parameters:
- CLK_HZ, 12_000_000: system clock frequency.
- BAUD, 115200: UART bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer floor; 104 at defaults.
- HALF_BIT, 6: system clocks per half period of LCLK (1 MHz LCLK at defaults). Minimum 2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- RX  in  1  UART line, idle high, asynchronous to CLK.
- o_rx_data  out  8  last received byte.
- o_rx_valid  out  1  one-cycle strobe, o_rx_data valid.
- i_valid  in  1  write request, sampled only when o_busy=0.
- i_pos  in  8  address command byte, or 0xFF = command-only transfer.
- i_value  in  8  data/command byte.
- o_lclk  out  1  LED driver clock.
- o_ldin  out  1  LED driver data.
- o_busy  out  1  writer busy.

Behaviour:
- Reset values (async on i_rst_n low):
  - o_rx_data=0, o_rx_valid=0, o_busy=0, o_lclk=1, o_ldin=1.
  - Both FSMs return to IDLE; any in-flight transfer is aborted.
- RX input handling: two-flop synchronizer, then falling-edge detect.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: wait CLKS_PER_BIT/2 cycles and re-sample. If the line is high, treat as a glitch and return to IDLE.
  - DATA: sample 8 bits, LSB first, each CLKS_PER_BIT apart at mid-bit.
  - STOP: sample at mid-bit, then load o_rx_data and pulse o_rx_valid for exactly one cycle. Return to IDLE at stop-bit mid-point so back-to-back frames are accepted.
  - o_rx_data holds its value until the next byte.
- Writer accept: if i_valid=1 and o_busy=0, latch i_pos/i_value and set o_busy the next cycle. i_valid while busy is ignored; no queueing.
- Writer frame: START, then byte(s), then STOP, then o_busy=0.
  - i_pos==0xFF: send i_value only.
  - Otherwise: send i_pos then i_value inside one START/STOP.
- START: LDIN falls while LCLK high; hold HALF_BIT, then LCLK low.
- Byte: 8 bits, LSB first.
  - LDIN changes only while LCLK is low.
  - Each bit: LCLK low for HALF_BIT, then high for HALF_BIT.
  - No ack bit.
- STOP: LCLK low with LDIN low for HALF_BIT; LCLK high for HALF_BIT; LDIN rises while LCLK high; hold HALF_BIT.
- o_busy drops the cycle after the stop hold completes. A new i_valid may be accepted on that same cycle.
- Writer and receiver are independent; simultaneous activity is allowed.
- Timing: 1-byte transfer = (2 + 16 + 3)·HALF_BIT cycles; 2-byte transfer = (2 + 32 + 3)·HALF_BIT cycles, ±1 cycle.

Optional Feature:
- Macro UART_FRAME_CHECK_EN.
- Defined: a stop bit sampled low is a framing error. No o_rx_valid is pulsed, o_rx_data is unchanged, and the FSM waits for RX high before returning to IDLE.
- Undefined: the byte is delivered regardless of the stop-bit value.

Test Plan:
- UART 0x41 ('A') at 115200 -> exactly one o_rx_valid pulse, o_rx_data=0x41, pulse at stop-bit mid-point (about 9.5·104 cycles after the start edge).
- Back-to-back bytes 0x55, 0xAA with no idle gap -> two pulses, data 0x55 then 0xAA.
- 20-cycle low glitch on RX -> no o_rx_valid. With UART_FRAME_CHECK_EN, byte 0x12 with stop bit low -> no pulse; without the macro -> pulse with 0x12.
- i_valid with i_pos=0xFF, i_value=0x89 -> START, LDIN bits 1,0,0,1,0,0,0,1 on LCLK rising edges, STOP; o_busy high for about 21·HALF_BIT cycles.
- i_pos=0xC3, i_value=0x81 -> one frame carrying 0xC3 then 0x81, LSB first. A second i_valid pulsed mid-transfer is ignored (only one frame observed).
- Assert i_rst_n low mid-transfer -> o_lclk=1, o_ldin=1, o_busy=0 immediately. A new request after release produces a clean, complete frame.
